// File: rtl/agdc.sv
// agdc: garage door controller, 3-state Moore FSM driving the door motor.
// Optional motion timeout enabled by defining AGDC_TIMEOUT_EN.
module agdc #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic CLK,
   input  logic RST,
   input  logic UP_Max,
   input  logic DN_Max,
   input  logic Activate,
   output logic UP_M,
   output logic DN_M
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MV_UP = 2'b01,
      MV_DN = 2'b10
   } state_e;

   state_e state_q, state_d;
   logic   tmo;

`ifdef AGDC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tmo = (cnt_q == CNT_LAST);

   // Motion age: zero while idle or on entry, counts each cycle in motion.
   always_comb begin
      cnt_d = '0;
      if ((state_q == MV_UP || state_q == MV_DN) && state_d == state_q)
         cnt_d = cnt_q + 1'b1;
   end

   // Motion age register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   // Timeout never fires in this build.
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   // Next-state: start only from a known end stop, stop at target limit.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (Activate && DN_Max && !UP_Max)
               state_d = MV_UP;
            else if (Activate && UP_Max && !DN_Max)
               state_d = MV_DN;
         end
         MV_UP: begin
            if (!UP_Max && !tmo) state_d = MV_UP;
         end
         MV_DN: begin
            if (!DN_Max && !tmo) state_d = MV_DN;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset stops the motor immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Moore output decode; the unused code drives nothing.
   always_comb begin
      UP_M = (state_q == MV_UP);
      DN_M = (state_q == MV_DN);
   end

endmodule

// File: tb/tb_agdc.sv
// tb_agdc: randomized and directed check of agdc against a door model.
// Build with AGDC_TIMEOUT_EN to also check the motion timeout.
module tb_agdc;

   localparam int TCYC = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic UP_Max = 1'b0;
   logic DN_Max = 1'b0;
   logic Activate = 1'b0;
   logic UP_M, DN_M;

   int vectors = 0;
   int errors = 0;

   // Model: door direction (+1 up, -1 down, 0 stopped) and motion age.
   int dir = 0;
   int age = 0;

   agdc #(.TIMEOUT_CYCLES(TCYC)) dut (
      .CLK(CLK),
      .RST(RST),
      .UP_Max(UP_Max),
      .DN_Max(DN_Max),
      .Activate(Activate),
      .UP_M(UP_M),
      .DN_M(DN_M)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         dir = 0;
         age = 0;
      end else if (dir == 0) begin
         age = 0;
         if (Activate && DN_Max && !UP_Max) dir = 1;
         else if (Activate && UP_Max && !DN_Max) dir = -1;
      end else begin
         age = age + 1;
         if (dir == 1 && UP_Max) dir = 0;
         else if (dir == -1 && DN_Max) dir = 0;
`ifdef AGDC_TIMEOUT_EN
         else if (age >= TCYC) dir = 0;
`endif
         if (dir == 0) age = 0;
      end
   end

   // Compare process: outputs must match the model every cycle.
   always @(negedge CLK) begin
      vectors++;
      if (UP_M !== (dir == 1) || DN_M !== (dir == -1)) begin
         errors++;
         $display("FAIL model: got up=%b dn=%b, want dir=%0d",
                  UP_M, DN_M, dir);
      end
   end

   task automatic chk(input string nm, input logic up, input logic dn);
      vectors++;
      if (UP_M !== up || DN_M !== dn) begin
         errors++;
         $display("FAIL %s: got %b/%b want %b/%b", nm, UP_M, DN_M, up, dn);
      end
   endtask

   task automatic drive(input logic a, input logic u, input logic d);
      Activate = a;
      UP_Max = u;
      DN_Max = d;
   endtask

   task automatic edge1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int ups;
      drive(1'b1, 1'b0, 1'b1);
      #2;
      chk("reset_hold", 1'b0, 1'b0);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      edge1();
      chk("after_reset", 1'b0, 1'b0);

      drive(1'b1, 1'b0, 1'b1);
      edge1();
      chk("open_start", 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("open_hold", 1'b1, 1'b0);
      end
      UP_Max = 1'b1;
      edge1();
      chk("open_stop", 1'b0, 1'b0);

      drive(1'b1, 1'b1, 1'b0);
      edge1();
      chk("close_start", 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("close_hold", 1'b0, 1'b1);
      end
      DN_Max = 1'b1;
      edge1();
      chk("close_stop", 1'b0, 1'b0);

      drive(1'b1, 1'b1, 1'b0);
      edge1();
      chk("mid_pre", 1'b0, 1'b1);
      #1;
      RST = 1'b0;
      #1;
      chk("mid_async", 1'b0, 1'b0);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      edge1();
      chk("mid_restart", 1'b0, 1'b1);
      DN_Max = 1'b1;
      edge1();
      chk("mid_stop", 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         case (k)
            0: drive(1'b1, 1'b1, 1'b1);
            1: drive(1'b1, 1'b0, 1'b0);
            2: drive(1'b0, 1'b0, 1'b0);
            3: drive(1'b0, 1'b0, 1'b1);
            4: drive(1'b0, 1'b1, 1'b0);
            default: drive(1'b0, 1'b1, 1'b1);
         endcase
         for (int i = 0; i < 4; i++) begin
            edge1();
            chk("illegal", 1'b0, 1'b0);
         end
      end

`ifdef AGDC_TIMEOUT_EN
      drive(1'b1, 1'b0, 1'b1);
      edge1();
      drive(1'b0, 1'b0, 1'b0);
      ups = 0;
      for (int i = 0; i < 20; i++) begin
         if (UP_M) ups++;
         edge1();
      end
      vectors++;
      if (ups != TCYC) begin
         errors++;
         $display("FAIL timeout_len: got %0d want %0d", ups, TCYC);
      end
      chk("timeout_stop", 1'b0, 1'b0);
`else
      drive(1'b1, 1'b0, 1'b1);
      edge1();
      drive(1'b0, 1'b0, 1'b0);
      ups = 0;
      for (int i = 0; i < 40; i++) begin
         if (UP_M) ups++;
         edge1();
      end
      vectors++;
      if (ups != 40) begin
         errors++;
         $display("FAIL no_timeout: got %0d want 40", ups);
      end
      UP_Max = 1'b1;
      edge1();
      chk("no_timeout_stop", 1'b0, 1'b0);
`endif

      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         #1;
         Activate = ($urandom_range(0, 3) != 0);
         UP_Max = ($urandom_range(0, 4) == 0);
         DN_Max = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 99) == 0) begin
            RST = 1'b0;
            #1;
            chk("rand_reset", 1'b0, 1'b0);
            #1;
            RST = 1'b1;
         end
      end

      @(negedge CLK);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
